// File: rtl/lsu_translation_arbiter.sv
// Round-robin arbiter sharing the data-side MMU translation port between the load and store pipes.
// A DTLB miss locks the grant to its requester until the translation resolves.

package riscv;
    localparam int unsigned VLEN = 39;
    localparam int unsigned PLEN = 56;
    localparam int unsigned XLEN = 64;

    typedef struct packed {
        logic [XLEN-1:0] cause;
        logic [XLEN-1:0] tval;
        logic            valid;
    } exception_t;
endpackage

module lsu_translation_arbiter #(
    parameter int unsigned CntWidth      = 16,
    parameter logic        StPriorityRst = 1'b0
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    flush_i,

    input  logic                    ld_req_i,
    input  logic [riscv::VLEN-1:0]  ld_vaddr_i,
    input  logic                    ld_hs_ld_st_inst_i,
    input  logic                    ld_hlvx_inst_i,
    output logic                    ld_gnt_o,
    output logic                    ld_dtlb_hit_o,
    output riscv::exception_t       ld_ex_o,

    input  logic                    st_req_i,
    input  logic [riscv::VLEN-1:0]  st_vaddr_i,
    input  logic                    st_hs_ld_st_inst_i,
    input  logic                    st_hlvx_inst_i,
    output logic                    st_gnt_o,
    output logic                    st_dtlb_hit_o,
    output riscv::exception_t       st_ex_o,

    output logic [riscv::PLEN-1:0]  paddr_o,

    output logic                    translation_req_o,
    output logic [riscv::VLEN-1:0]  vaddr_o,
    output logic                    hs_ld_st_inst_o,
    output logic                    hlvx_inst_o,
    input  logic [riscv::PLEN-1:0]  paddr_i,
    input  riscv::exception_t       ex_i,
    input  logic                    dtlb_hit_i,

    output logic [CntWidth-1:0]     stall_cnt_o
);

    typedef enum logic {
        LD = 1'b0,
        ST = 1'b1
    } requester_e;

    localparam requester_e RrRst = requester_e'(StPriorityRst);

    logic                lock_q, lock_d;
    requester_e          owner_q, owner_d;
    requester_e          rr_q, rr_d;
    logic [CntWidth-1:0] stall_cnt_q, stall_cnt_d;

    requester_e winner;
    logic       winner_req;
    logic       any_req;
    logic       granted;
    logic       resolved;

    // Winner selection: a held lock beats everything, then a lone requester, then the rr pointer.
    always_comb begin
        winner = rr_q;
        if (lock_q) begin
            winner = owner_q;
        end else if (ld_req_i && !st_req_i) begin
            winner = LD;
        end else if (st_req_i && !ld_req_i) begin
            winner = ST;
        end
    end

    // While in reset the port looks idle even if the pipes are still requesting.
    assign winner_req = (winner == ST) ? st_req_i : ld_req_i;
    assign any_req    = rst_ni && (ld_req_i || st_req_i);
    assign granted    = rst_ni && winner_req;
    assign resolved   = granted && (dtlb_hit_i || ex_i.valid);

    // Request datapath towards the MMU.
    always_comb begin
        translation_req_o = granted;
        vaddr_o           = '0;
        hs_ld_st_inst_o   = 1'b0;
        hlvx_inst_o       = 1'b0;
        if (any_req) begin
            if (winner == ST) begin
                vaddr_o         = st_vaddr_i;
                hs_ld_st_inst_o = st_hs_ld_st_inst_i;
                hlvx_inst_o     = st_hlvx_inst_i;
            end else begin
                vaddr_o         = ld_vaddr_i;
                hs_ld_st_inst_o = ld_hs_ld_st_inst_i;
                hlvx_inst_o     = ld_hlvx_inst_i;
            end
        end
    end

    // Response datapath: only the granted requester sees the hit and exception.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no path infers a latch.
        ld_gnt_o      = 1'b0;
        st_gnt_o      = 1'b0;
        ld_dtlb_hit_o = 1'b0;
        st_dtlb_hit_o = 1'b0;
        ld_ex_o       = '0;
        st_ex_o       = '0;
        if (granted) begin
            if (winner == ST) begin
                st_gnt_o      = 1'b1;
                st_dtlb_hit_o = dtlb_hit_i;
                st_ex_o       = ex_i;
            end else begin
                ld_gnt_o      = 1'b1;
                ld_dtlb_hit_o = dtlb_hit_i;
                ld_ex_o       = ex_i;
            end
        end
    end

    assign paddr_o     = paddr_i;
    assign stall_cnt_o = stall_cnt_q;

    // Lock, round-robin and stall-counter next state.
    always_comb begin
        lock_d      = 1'b0;
        owner_d     = owner_q;
        rr_d        = rr_q;
        stall_cnt_d = stall_cnt_q;

        // A flush, a resolution or the owner dropping its request all leave lock_d at 0.
        if (!flush_i && granted && !resolved) begin
            lock_d  = 1'b1;
            owner_d = winner;
        end

        if (resolved) begin
            rr_d = (winner == LD) ? ST : LD;
        end

        if (granted && !resolved && !(&stall_cnt_q)) begin
            stall_cnt_d = stall_cnt_q + CntWidth'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            lock_q      <= 1'b0;
            owner_q     <= LD;
            rr_q        <= RrRst;
            stall_cnt_q <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
            lock_q      <= lock_d;
            owner_q     <= owner_d;
            rr_q        <= rr_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

endmodule

// File: tb/tb_lsu_translation_arbiter.sv
// Self-checking bench for lsu_translation_arbiter: directed scenarios followed by a randomized phase,
// all compared against a cycle-level reference model of the arbitration rules.

module tb_lsu_translation_arbiter;
    import riscv::*;

    localparam int unsigned SatWidth = 4;

    logic clk;
    logic rst_n;
    logic flush;

    logic            ld_req, ld_hs, ld_hlvx;
    logic [VLEN-1:0] ld_vaddr;
    logic            st_req, st_hs, st_hlvx;
    logic [VLEN-1:0] st_vaddr;
    logic [PLEN-1:0] paddr_in;
    exception_t      ex_in;
    logic            dtlb_hit;

    logic            ld_gnt, ld_hit, st_gnt, st_hit;
    exception_t      ld_ex, st_ex;
    logic [PLEN-1:0] paddr_out;
    logic            tr_req;
    logic [VLEN-1:0] vaddr_out;
    logic            hs_out, hlvx_out;
    logic [15:0]     stall_cnt;

    logic                ld_gnt_s, ld_hit_s, st_gnt_s, st_hit_s;
    exception_t          ld_ex_s, st_ex_s;
    logic [PLEN-1:0]     paddr_out_s;
    logic                tr_req_s;
    logic [VLEN-1:0]     vaddr_out_s;
    logic                hs_out_s, hlvx_out_s;
    logic [SatWidth-1:0] stall_cnt_s;

    lsu_translation_arbiter dut (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(flush),
        .ld_req_i(ld_req), .ld_vaddr_i(ld_vaddr), .ld_hs_ld_st_inst_i(ld_hs), .ld_hlvx_inst_i(ld_hlvx),
        .ld_gnt_o(ld_gnt), .ld_dtlb_hit_o(ld_hit), .ld_ex_o(ld_ex),
        .st_req_i(st_req), .st_vaddr_i(st_vaddr), .st_hs_ld_st_inst_i(st_hs), .st_hlvx_inst_i(st_hlvx),
        .st_gnt_o(st_gnt), .st_dtlb_hit_o(st_hit), .st_ex_o(st_ex),
        .paddr_o(paddr_out), .translation_req_o(tr_req), .vaddr_o(vaddr_out),
        .hs_ld_st_inst_o(hs_out), .hlvx_inst_o(hlvx_out),
        .paddr_i(paddr_in), .ex_i(ex_in), .dtlb_hit_i(dtlb_hit), .stall_cnt_o(stall_cnt)
    );

    lsu_translation_arbiter #(.CntWidth(SatWidth)) dut_sat (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(flush),
        .ld_req_i(ld_req), .ld_vaddr_i(ld_vaddr), .ld_hs_ld_st_inst_i(ld_hs), .ld_hlvx_inst_i(ld_hlvx),
        .ld_gnt_o(ld_gnt_s), .ld_dtlb_hit_o(ld_hit_s), .ld_ex_o(ld_ex_s),
        .st_req_i(st_req), .st_vaddr_i(st_vaddr), .st_hs_ld_st_inst_i(st_hs), .st_hlvx_inst_i(st_hlvx),
        .st_gnt_o(st_gnt_s), .st_dtlb_hit_o(st_hit_s), .st_ex_o(st_ex_s),
        .paddr_o(paddr_out_s), .translation_req_o(tr_req_s), .vaddr_o(vaddr_out_s),
        .hs_ld_st_inst_o(hs_out_s), .hlvx_inst_o(hlvx_out_s),
        .paddr_i(paddr_in), .ex_i(ex_in), .dtlb_hit_i(dtlb_hit), .stall_cnt_o(stall_cnt_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: which requester is pinned (-1 = none), who the tie goes to, stall tallies.
    int pinned  = -1;
    int tie_to  = 0;
    int cnt_big = 0;
    int cnt_sat = 0;

    // Outcome of the most recent step, for directed follow-up checks and the random driver.
    int  last_w;
    bit  last_g;
    bit  last_res;
    bit  last_flush;
    logic obs_ld_gnt, obs_st_gnt;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [VLEN-1:0] rand_vaddr();
        logic [63:0] r;
        r = {$urandom, $urandom};
        return r[VLEN-1:0];
    endfunction

    function automatic logic [PLEN-1:0] rand_paddr();
        logic [63:0] r;
        r = {$urandom, $urandom};
        return r[PLEN-1:0];
    endfunction

    task automatic set_mmu(input bit hit, input bit exv);
        dtlb_hit    = hit;
        ex_in.valid = exv;
        ex_in.cause = exv ? 64'hd : 64'h0;
        ex_in.tval  = exv ? {$urandom, $urandom} : 64'h0;
        paddr_in    = rand_paddr();
    endtask

    // Called just after a rising edge with inputs settled: checks this cycle, then advances one clock.
    task automatic step();
        int  w;
        bit  g, res, to_ld, to_st;
        logic [VLEN-1:0] exp_va;
        logic exp_hs, exp_hlvx;
        #3;
        if (pinned >= 0)          w = pinned;
        else if (ld_req && !st_req) w = 0;
        else if (st_req && !ld_req) w = 1;
        else                      w = tie_to;
        g     = (w == 1) ? st_req : ld_req;
        res   = g && (dtlb_hit || ex_in.valid);
        to_ld = g && (w == 0);
        to_st = g && (w == 1);

        check("ld_gnt",   ld_gnt, to_ld);
        check("st_gnt",   st_gnt, to_st);
        check("tr_req",   tr_req, g);
        check("ld_hit",   ld_hit, to_ld && dtlb_hit);
        check("st_hit",   st_hit, to_st && dtlb_hit);
        check("ld_ex_v",  ld_ex.valid, to_ld && ex_in.valid);
        check("st_ex_v",  st_ex.valid, to_st && ex_in.valid);
        check("ld_ex_c",  ld_ex.cause, to_ld ? ex_in.cause : 64'h0);
        check("st_ex_t",  st_ex.tval, to_st ? ex_in.tval : 64'h0);
        check("paddr",    paddr_out, paddr_in);
        check("stall",    stall_cnt, cnt_big);
        check("stall_s",  stall_cnt_s, cnt_sat);
        if (g) begin
            exp_va   = (w == 1) ? st_vaddr : ld_vaddr;
            exp_hs   = (w == 1) ? st_hs : ld_hs;
            exp_hlvx = (w == 1) ? st_hlvx : ld_hlvx;
            check("vaddr", vaddr_out, exp_va);
            check("hs",    hs_out, exp_hs);
            check("hlvx",  hlvx_out, exp_hlvx);
        end
        obs_ld_gnt = ld_gnt;
        obs_st_gnt = st_gnt;

        @(posedge clk);
        // A granted but unanswered request pins the port unless a flush lands in the same cycle.
        pinned = (g && !res && !flush) ? w : -1;
        if (res) tie_to = 1 - w;
        if (g && !res) begin
            cnt_big = (cnt_big < 65535) ? cnt_big + 1 : 65535;
            cnt_sat = (cnt_sat < 15) ? cnt_sat + 1 : 15;
        end
        last_w     = w;
        last_g     = g;
        last_res   = res;
        last_flush = flush;
        #1;
    endtask

    initial begin
        int ld_hits, st_hits, ld_grants;

        rst_n    = 1'b0;
        flush    = 1'b0;
        ld_req   = 1'b0; ld_vaddr = '0; ld_hs = 1'b0; ld_hlvx = 1'b0;
        st_req   = 1'b0; st_vaddr = '0; st_hs = 1'b0; st_hlvx = 1'b0;
        set_mmu(1'b0, 1'b0);

        repeat (3) @(posedge clk);
        #1;
        check("rst_ld_gnt", ld_gnt, 1'b0);
        check("rst_st_gnt", st_gnt, 1'b0);
        check("rst_tr_req", tr_req, 1'b0);
        check("rst_stall",  stall_cnt, 16'd0);
        rst_n = 1'b1;

        // Lone store that hits immediately.
        st_req = 1'b1; st_vaddr = VLEN'(64'h8000_1000); st_hs = 1'b1;
        set_mmu(1'b1, 1'b0);
        step();
        check("t1_st_gnt", obs_st_gnt, 1'b1);
        check("t1_stall",  stall_cnt, 16'd0);

        // Both requesting, every translation hits: strict alternation starting with load.
        ld_req = 1'b1; ld_vaddr = rand_vaddr(); st_vaddr = rand_vaddr();
        ld_hits = 0; st_hits = 0;
        for (int i = 0; i < 4; i++) begin
            set_mmu(1'b1, 1'b0);
            step();
            if (obs_ld_gnt) ld_hits++;
            if (obs_st_gnt) st_hits++;
            check("t2_alt_ld", obs_ld_gnt, (i % 2) == 0);
        end
        check("t2_ld_hits", ld_hits, 2);
        check("t2_st_hits", st_hits, 2);

        // Load misses five times then hits; the store waits throughout.
        ld_grants = 0;
        for (int i = 0; i < 6; i++) begin
            set_mmu(i == 5, 1'b0);
            step();
            if (obs_ld_gnt) ld_grants++;
        end
        check("t3_ld_grants", ld_grants, 6);
        check("t3_stall", stall_cnt, 16'd5);
        set_mmu(1'b1, 1'b0);
        ld_req = 1'b0;
        step();
        check("t3_st_after", obs_st_gnt, 1'b1);

        // Store locks on a miss, then takes a page fault on its third cycle.
        st_req = 1'b1; st_vaddr = rand_vaddr();
        set_mmu(1'b0, 1'b0);
        step();
        ld_req = 1'b1; ld_vaddr = rand_vaddr();
        step();
        set_mmu(1'b0, 1'b1);
        step();
        check("t4_st_fault_gnt", obs_st_gnt, 1'b1);
        st_req = 1'b0;
        set_mmu(1'b0, 1'b0);
        step();
        check("t4_ld_next", obs_ld_gnt, 1'b1);

        // Load is locked; a flush kills it and the store gets the port next cycle.
        st_req = 1'b1; st_vaddr = rand_vaddr();
        flush = 1'b1;
        step();
        flush  = 1'b0;
        ld_req = 1'b0;
        step();
        check("t5_st_after_flush", obs_st_gnt, 1'b1);

        // Long unresolved stretch saturates the narrow counter.
        st_req = 1'b0;
        ld_req = 1'b1; ld_vaddr = rand_vaddr();
        for (int i = 0; i < 20; i++) begin
            set_mmu(1'b0, 1'b0);
            step();
        end
        check("t6_sat", stall_cnt_s, 4'hf);

        // Asynchronous reset mid-lock with a hit pending: outputs idle immediately.
        set_mmu(1'b1, 1'b0);
        st_req = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_ld_gnt", ld_gnt, 1'b0);
        check("arst_st_gnt", st_gnt, 1'b0);
        check("arst_tr_req", tr_req, 1'b0);
        check("arst_ld_hit", ld_hit, 1'b0);
        check("arst_st_hit", st_hit, 1'b0);
        check("arst_stall",  stall_cnt, 16'd0);
        check("arst_stall_s", stall_cnt_s, 4'd0);
        pinned = -1; tie_to = 0; cnt_big = 0; cnt_sat = 0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        st_req = 1'b0;
        step();

        // Randomized traffic against the model; requesters mostly hold until served.
        for (int n = 0; n < 600; n++) begin
            if ((last_g && last_res && last_w == 0) || (last_flush && $urandom_range(0, 1) == 0)
                || $urandom_range(0, 24) == 0)
                ld_req = 1'b0;
            if ((last_g && last_res && last_w == 1) || (last_flush && $urandom_range(0, 1) == 0)
                || $urandom_range(0, 24) == 0)
                st_req = 1'b0;
            if (!ld_req && $urandom_range(0, 1) == 1) begin
                ld_req = 1'b1; ld_vaddr = rand_vaddr();
                ld_hs = 1'($urandom); ld_hlvx = 1'($urandom);
            end
            if (!st_req && $urandom_range(0, 1) == 1) begin
                st_req = 1'b1; st_vaddr = rand_vaddr();
                st_hs = 1'($urandom); st_hlvx = 1'($urandom);
            end
            if ($urandom_range(0, 19) == 0) ld_vaddr = rand_vaddr();
            flush = ($urandom_range(0, 15) == 0);
            set_mmu($urandom_range(0, 2) == 0, $urandom_range(0, 9) == 0);
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
